// File: rtl/mu_arbiter_if.sv
// MemoryUnit-style request/response handshake shared by the requesters and the MemoryUnit.
// The master drives the request; the slave answers with busy and read data.
interface mu_arbiter_if;
  logic [26:0] address;
  logic [31:0] data;
  logic        we;
  logic        start;
  logic        busy;
  logic [31:0] q;

  modport master (output address, data, we, start, input busy, q);
  modport slave  (input address, data, we, start, output busy, q);
endinterface

// File: rtl/mu_arbiter.sv
// Shares one MemoryUnit between cpu and dma: latches each request, grants one at a time
// (round-robin or cpu-first), and returns the completion data to the owner only.
module mu_arbiter_port (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [26:0] address,
  input  logic [31:0] data,
  input  logic        we,
  input  logic        done,
  input  logic        q_load,
  input  logic [31:0] mu_q,
  output logic        pend,
  output logic [26:0] hold_address,
  output logic [31:0] hold_data,
  output logic        hold_we,
  output logic [31:0] q
);
  // done only ever arrives while pend is set, so a start in the DONE cycle is dropped
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pend         <= 1'b0;
      hold_address <= '0;
      hold_data    <= '0;
      hold_we      <= 1'b0;
      q            <= '0;
    end else begin
      if (done) begin
        pend <= 1'b0;
      end else if (start && !pend) begin
        pend         <= 1'b1;
        hold_address <= address;
        hold_data    <= data;
        hold_we      <= we;
      end
      if (q_load) q <= mu_q;
    end
  end
endmodule

module mu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         nreset,
  mu_arbiter_if.slave  cpu,
  mu_arbiter_if.slave  dma,
  mu_arbiter_if.master mu
);
  localparam int NUM_PORTS = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // port index 0 = cpu, 1 = dma
  logic [NUM_PORTS-1:0]       req_start, req_we, pend, hold_we, done_v, load_v;
  logic [NUM_PORTS-1:0][26:0] req_address, hold_address;
  logic [NUM_PORTS-1:0][31:0] req_data, hold_data, q_v;

  logic [1:0]  state;
  logic        owner, last_grant, grant_sel, busy_seen, complete;
  logic [26:0] mu_address_r;
  logic [31:0] mu_data_r;
  logic        mu_we_r, mu_start_r;

  assign req_start   = {dma.start, cpu.start};
  assign req_we      = {dma.we, cpu.we};
  assign req_address = {dma.address, cpu.address};
  assign req_data    = {dma.data, cpu.data};

  assign cpu.busy = pend[0];
  assign cpu.q    = q_v[0];
  assign dma.busy = pend[1];
  assign dma.q    = q_v[1];

  assign mu.address = mu_address_r;
  assign mu.data    = mu_data_r;
  assign mu.we      = mu_we_r;
  assign mu.start   = mu_start_r;

  // completion needs busy to have been seen high first; early-low busy is ignored
  assign complete = (state == S_WAIT) && busy_seen && !mu.busy;
  assign load_v   = complete ? {owner, ~owner} : '0;
  assign done_v   = (state == S_DONE) ? {owner, ~owner} : '0;

  always_comb begin
    grant_sel = pend[1];
    if (&pend) grant_sel = FIXED_PRIO ? 1'b0 : ~last_grant;
  end

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      mu_arbiter_port u_port (
        .clk          (clk),
        .nreset       (nreset),
        .start        (req_start[i]),
        .address      (req_address[i]),
        .data         (req_data[i]),
        .we           (req_we[i]),
        .done         (done_v[i]),
        .q_load       (load_v[i]),
        .mu_q         (mu.q),
        .pend         (pend[i]),
        .hold_address (hold_address[i]),
        .hold_data    (hold_data[i]),
        .hold_we      (hold_we[i]),
        .q            (q_v[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= S_IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      busy_seen    <= 1'b0;
      mu_address_r <= '0;
      mu_data_r    <= '0;
      mu_we_r      <= 1'b0;
      mu_start_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|pend) begin
            owner        <= grant_sel;
            last_grant   <= grant_sel;
            mu_address_r <= hold_address[grant_sel];
            mu_data_r    <= hold_data[grant_sel];
            mu_we_r      <= hold_we[grant_sel];
            mu_start_r   <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mu_start_r <= 1'b0;
          busy_seen  <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (mu.busy) busy_seen <= 1'b1;
          if (complete) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
